mod_updown_counter: RTL and testbench

//  Parametrised up/down modulo counter; next generation of the FIFO up counter.

---
 rtl/mod_updown_counter.sv | 107 ++++++++++
 tb/tb_mod_updown_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, sync clear and wrap-or-saturate limits.
// Serves as a FIFO pointer (wrap mode, with wrap_bit) or an occupancy count (saturate mode).
module mod_updown_counter #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            up_en,
  input  logic            up_blk,
  input  logic            dn_en,
  input  logic            dn_blk,
  output logic [SIZE-1:0] count,
  output logic            wrap_bit,
  output logic            at_max,
  output logic            at_zero,
  output logic            wrapped,
  output logic            limit_hit
);

  // MODULUS may equal 2**SIZE, so the range check needs one extra bit.
  localparam logic [SIZE-1:0] MAX_VAL = SIZE'(MODULUS - 1);
  localparam logic [SIZE:0]   MOD_EXT = (SIZE + 1)'(MODULUS);

  logic [SIZE-1:0] count_q, count_d;
  logic            wrap_bit_q, wrap_bit_d;
  logic            wrapped_q, wrapped_d;
  logic            limit_hit_q, limit_hit_d;

  logic step_up;
  logic step_dn;
  logic load_over;

  assign step_up   = up_en & ~up_blk;
  assign step_dn   = dn_en & ~dn_blk;
  assign load_over = ({1'b0, load_val} >= MOD_EXT);

  // Next-state: clear beats load beats step; opposing steps cancel.
  always_comb begin
    count_d     = count_q;
    wrap_bit_d  = wrap_bit_q;
    wrapped_d   = 1'b0;
    limit_hit_d = 1'b0;

    if (clear) begin
      count_d    = '0;
      wrap_bit_d = 1'b0;
    end else if (load) begin
      if (load_over) begin
        count_d     = MAX_VAL;
        limit_hit_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (step_up && !step_dn) begin
      if (count_q == MAX_VAL) begin
        if (SATURATE) begin
          limit_hit_d = 1'b1;
        end else begin
          count_d    = '0;
          wrap_bit_d = ~wrap_bit_q;
          wrapped_d  = 1'b1;
        end
      end else begin
        count_d = count_q + SIZE'(1);
      end
    end else if (step_dn && !step_up) begin
      if (count_q == '0) begin
        if (SATURATE) begin
          limit_hit_d = 1'b1;
        end else begin
          count_d    = MAX_VAL;
          wrap_bit_d = ~wrap_bit_q;
          wrapped_d  = 1'b1;
        end
      end else begin
        count_d = count_q - SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q     <= '0;
      wrap_bit_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wrap_bit_q  <= wrap_bit_d;
      wrapped_q   <= wrapped_d;
      limit_hit_q <= limit_hit_d;
    end
  end

  assign count     = count_q;
  assign wrap_bit  = wrap_bit_q;
  assign wrapped   = wrapped_q;
  assign limit_hit = limit_hit_q;
  assign at_max    = (count_q == MAX_VAL);
  assign at_zero   = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Random and directed bench for mod_updown_counter: a wrap and a saturate instance
// (SIZE=4, MODULUS=10) share inputs and are compared against an integer reference model.
module tb_mod_updown_counter;

  localparam int unsigned SIZE = 4;
  localparam int          M    = 10;

  logic            clk;
  logic            n_rst;
  logic            clear;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic            up_en, up_blk, dn_en, dn_blk;

  logic [SIZE-1:0] count_w, count_s;
  logic            wrap_bit_w, wrap_bit_s;
  logic            at_max_w, at_max_s;
  logic            at_zero_w, at_zero_s;
  logic            wrapped_w, wrapped_s;
  logic            limit_hit_w, limit_hit_s;

  int total;
  int bad;

  // Reference state, index 0 = wrap instance, 1 = saturate instance.
  int m_cnt[2];
  int m_wb[2];
  int m_wr[2];
  int m_lh[2];

  mod_updown_counter #(.SIZE(SIZE), .MODULUS(M), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .up_en(up_en), .up_blk(up_blk), .dn_en(dn_en), .dn_blk(dn_blk),
    .count(count_w), .wrap_bit(wrap_bit_w), .at_max(at_max_w), .at_zero(at_zero_w),
    .wrapped(wrapped_w), .limit_hit(limit_hit_w)
  );

  mod_updown_counter #(.SIZE(SIZE), .MODULUS(M), .SATURATE(1'b1)) u_sat (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .up_en(up_en), .up_blk(up_blk), .dn_en(dn_en), .dn_blk(dn_blk),
    .count(count_s), .wrap_bit(wrap_bit_s), .at_max(at_max_s), .at_zero(at_zero_s),
    .wrapped(wrapped_s), .limit_hit(limit_hit_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_wb[i] = 0; m_wr[i] = 0; m_lh[i] = 0;
    end
  endtask

  // Counter semantics as integer arithmetic: out-of-range results either fold or are refused.
  task automatic model_edge(input bit clr, input bit ld, input int lv,
                            input bit u, input bit ub, input bit d, input bit db);
    for (int i = 0; i < 2; i++) begin
      int net;
      int nxt;
      m_wr[i] = 0;
      m_lh[i] = 0;
      if (clr) begin
        m_cnt[i] = 0;
        m_wb[i]  = 0;
      end else if (ld) begin
        if (lv >= M) begin
          m_cnt[i] = M - 1;
          m_lh[i]  = 1;
        end else begin
          m_cnt[i] = lv;
        end
      end else begin
        net = ((u && !ub) ? 1 : 0) - ((d && !db) ? 1 : 0);
        nxt = m_cnt[i] + net;
        if (nxt < 0 || nxt >= M) begin
          if (i == 1) begin
            m_lh[i] = 1;
          end else begin
            m_cnt[i] = (nxt + M) % M;
            m_wb[i]  = 1 - m_wb[i];
            m_wr[i]  = 1;
          end
        end else begin
          m_cnt[i] = nxt;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":w.count"},     32'(count_w),     32'(m_cnt[0]));
    chk({tag, ":w.wrap_bit"},  32'(wrap_bit_w),  32'(m_wb[0]));
    chk({tag, ":w.wrapped"},   32'(wrapped_w),   32'(m_wr[0]));
    chk({tag, ":w.limit_hit"}, 32'(limit_hit_w), 32'(m_lh[0]));
    chk({tag, ":w.at_max"},    32'(at_max_w),    32'(m_cnt[0] == M - 1));
    chk({tag, ":w.at_zero"},   32'(at_zero_w),   32'(m_cnt[0] == 0));
    chk({tag, ":s.count"},     32'(count_s),     32'(m_cnt[1]));
    chk({tag, ":s.wrap_bit"},  32'(wrap_bit_s),  32'(m_wb[1]));
    chk({tag, ":s.wrapped"},   32'(wrapped_s),   32'(m_wr[1]));
    chk({tag, ":s.limit_hit"}, 32'(limit_hit_s), 32'(m_lh[1]));
    chk({tag, ":s.at_max"},    32'(at_max_s),    32'(m_cnt[1] == M - 1));
    chk({tag, ":s.at_zero"},   32'(at_zero_s),   32'(m_cnt[1] == 0));
  endtask

  // One clocked step: drive, clock, advance model, sample 1 time unit after the edge.
  task automatic step(input string tag, input bit clr, input bit ld, input int lv,
                      input bit u, input bit ub, input bit d, input bit db);
    clear = clr; load = ld; load_val = SIZE'(lv);
    up_en = u; up_blk = ub; dn_en = d; dn_blk = db;
    @(posedge clk);
    model_edge(clr, ld, lv, u, ub, d, db);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    chk({tag, ":w.count_now"},   32'(count_w),    32'd0);
    chk({tag, ":w.wrap_now"},    32'(wrap_bit_w), 32'd0);
    chk({tag, ":w.at_zero_now"}, 32'(at_zero_w),  32'd1);
    check_all(tag);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
    up_en = 1'b0; up_blk = 1'b0; dn_en = 1'b0; dn_blk = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Async reset mid-count at 5, between edges.
    for (int k = 0; k < 5; k++) step("t1_up", 0, 0, 0, 1, 0, 0, 0);
    chk("t1_pre_count", 32'(count_w), 32'd5);
    async_reset("t1_rst");

    // Wrap up: 12 steps from 0 lands on 2 with wrap_bit set.
    for (int k = 0; k < 12; k++) step("t2_up", 0, 0, 0, 1, 0, 0, 0);
    chk("t2_count", 32'(count_w), 32'd2);
    chk("t2_wrap_bit", 32'(wrap_bit_w), 32'd1);
    chk("t2_wrapped_gone", 32'(wrapped_w), 32'd0);
    chk("t2_sat_count", 32'(count_s), 32'd9);

    // Wrap down from 0, then up&dn together holds.
    step("t3_clr", 1, 0, 0, 0, 0, 0, 0);
    step("t3_dn", 0, 0, 0, 0, 0, 1, 0);
    chk("t3_count", 32'(count_w), 32'd9);
    chk("t3_wrapped", 32'(wrapped_w), 32'd1);
    chk("t3_sat_hit", 32'(limit_hit_s), 32'd1);
    step("t3_both", 0, 0, 0, 1, 0, 1, 0);
    chk("t3_hold", 32'(count_w), 32'd9);

    // Saturate: 15 ups stick at 9; dn at 0 holds.
    step("t4_clr", 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) step("t4_up", 0, 0, 0, 1, 0, 0, 0);
    chk("t4_sat_count", 32'(count_s), 32'd9);
    chk("t4_sat_at_max", 32'(at_max_s), 32'd1);
    chk("t4_sat_hit", 32'(limit_hit_s), 32'd1);
    step("t4_clr2", 1, 0, 0, 0, 0, 0, 0);
    step("t4_dn0", 0, 0, 0, 0, 0, 1, 0);
    chk("t4_sat_zero", 32'(count_s), 32'd0);

    // Blocking and priority.
    step("t5_blk", 0, 0, 0, 1, 1, 0, 0);
    step("t5_prio", 1, 1, 7, 1, 0, 0, 0);
    chk("t5_prio_count", 32'(count_w), 32'd0);
    step("t5_load", 0, 1, 7, 1, 0, 0, 0);
    chk("t5_load_count", 32'(count_w), 32'd7);

    // Load clamp, with wrap_bit set beforehand so "unchanged" is visible.
    step("t6_dn", 0, 1, 0, 0, 0, 0, 0);
    step("t6_wrap", 0, 0, 0, 0, 0, 1, 0);
    step("t6_clamp", 0, 1, 12, 0, 0, 0, 0);
    chk("t6_count", 32'(count_w), 32'd9);
    chk("t6_hit", 32'(limit_hit_w), 32'd1);
    chk("t6_wrap_kept", 32'(wrap_bit_w), 32'd1);
    step("t6_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("t6_hit_gone", 32'(limit_hit_w), 32'd0);

    // Random traffic with one mid-run async reset.
    for (int k = 0; k < 3000; k++) begin
      bit clr, ld, u, ub, d, db;
      int lv;
      clr = ($urandom_range(31) == 0);
      ld  = ($urandom_range(7) == 0);
      lv  = int'($urandom_range(15));
      u   = $urandom_range(1) == 1;
      d   = $urandom_range(1) == 1;
      ub  = ($urandom_range(3) == 0);
      db  = ($urandom_range(3) == 0);
      step("rnd", clr, ld, lv, u, ub, d, db);
      if (k == 1500) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
